// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - buffered, handshaked RV32I decode stage with FIFO, flush and illegal detection
module decode_stage #(
    parameter int QUEUE_DEPTH = 4,
    parameter bit ENABLE_M    = 1'b0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [31:0]                    in_instr,
    input  logic [31:0]                    in_pc,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [31:0]                    out_pc,
    output logic [4:0]                     out_rs1,
    output logic [4:0]                     out_rs2,
    output logic [4:0]                     out_rd,
    output logic [2:0]                     out_funct3,
    output logic [6:0]                     out_funct7,
    output logic                           out_branch,
    output logic                           out_jump,
    output logic                           out_jump_src,
    output logic [2:0]                     out_alu_op,
    output logic                           out_alu_src_a,
    output logic [1:0]                     out_alu_src_b,
    output logic                           out_mem_read,
    output logic                           out_mem_write,
    output logic [1:0]                     out_mem_mask,
    output logic                           out_mem_sext,
    output logic                           out_reg_write,
    output logic [1:0]                     out_wb_src,
    output logic                           out_illegal,
    output logic [$clog2(QUEUE_DEPTH):0]   occupancy
);

    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        branch;
        logic        jump;
        logic        jump_src;
        logic [2:0]  alu_op;
        logic        alu_src_a;
        logic [1:0]  alu_src_b;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_mask;
        logic        mem_sext;
        logic        reg_write;
        logic [1:0]  wb_src;
        logic        illegal;
    } ctrl_t;

    logic [31:0]   instr_mem_q [QUEUE_DEPTH];
    logic [31:0]   pc_mem_q    [QUEUE_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          out_valid_q, out_valid_d;
    ctrl_t         out_q, out_d;
    ctrl_t         dec;
    logic          push, pop, legal;
    logic [31:0]   head_instr;
    logic [6:0]    opcode, funct7;
    logic [2:0]    funct3;

    // in_ready must never look at out_ready so there is no comb path through the stage
    assign in_ready = !flush && rst_n && (count_q < CW'(QUEUE_DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = !flush && (count_q != '0) && (!out_valid_q || out_ready);

    assign head_instr = instr_mem_q[rd_ptr_q];
    assign opcode     = head_instr[6:0];
    assign funct3     = head_instr[14:12];
    assign funct7     = head_instr[31:25];

    always_comb begin
        dec           = '0;
        dec.mem_mask  = 2'b11;
        legal         = 1'b1;
        dec.pc        = pc_mem_q[rd_ptr_q];
        dec.rs1       = head_instr[19:15];
        dec.rs2       = head_instr[24:20];
        dec.rd        = head_instr[11:7];
        dec.funct3    = funct3;
        dec.funct7    = funct7;
        case (opcode)
            OPC_OP: begin
                dec.reg_write = 1'b1;
                dec.alu_op    = 3'b010;
                if (ENABLE_M && funct7 == 7'b0000001) begin
                    dec.alu_op = 3'b100;
                end else if (funct7 == 7'b0100000) begin
                    legal = (funct3 == 3'd0) || (funct3 == 3'd5);
                end else if (funct7 != 7'b0000000) begin
                    legal = 1'b0;
                end
            end
            OPC_OP_IMM: begin
                dec.alu_op    = 3'b011;
                dec.alu_src_b = 2'b01;
                dec.reg_write = 1'b1;
                if (funct3 == 3'd1 && funct7 != 7'b0000000) begin
                    legal = 1'b0;
                end
                if (funct3 == 3'd5 && funct7 != 7'b0000000 && funct7 != 7'b0100000) begin
                    legal = 1'b0;
                end
            end
            OPC_LOAD: begin
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                dec.wb_src    = 2'b01;
                dec.alu_src_b = 2'b01;
                case (funct3)
                    3'd0:    begin dec.mem_mask = 2'b01; dec.mem_sext = 1'b1; end
                    3'd1:    begin dec.mem_mask = 2'b10; dec.mem_sext = 1'b1; end
                    3'd2:    begin dec.mem_mask = 2'b11; dec.mem_sext = 1'b1; end
                    3'd4:    dec.mem_mask = 2'b01;
                    3'd5:    dec.mem_mask = 2'b10;
                    default: legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                dec.mem_write = 1'b1;
                dec.alu_src_b = 2'b01;
                case (funct3)
                    3'd0:    dec.mem_mask = 2'b01;
                    3'd1:    dec.mem_mask = 2'b10;
                    3'd2:    dec.mem_mask = 2'b11;
                    default: legal = 1'b0;
                endcase
            end
            OPC_BRANCH: begin
                dec.branch = 1'b1;
                dec.alu_op = 3'b001;
                legal      = !(funct3 == 3'd2 || funct3 == 3'd3);
            end
            OPC_JAL: begin
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.wb_src    = 2'b10;
            end
            OPC_JALR: begin
                dec.jump      = 1'b1;
                dec.jump_src  = 1'b1;
                dec.alu_op    = 3'b011;
                dec.alu_src_b = 2'b01;
                dec.reg_write = 1'b1;
                dec.wb_src    = 2'b10;
                legal         = (funct3 == 3'd0);
            end
            OPC_LUI: begin
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 2'b01;
                dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_src_a = 1'b1;
                dec.alu_src_b = 2'b10;
                dec.reg_write = 1'b1;
            end
            OPC_FENCE: ;
            default: legal = 1'b0;
        endcase
        // illegal words still travel downstream, but must not cause any side effect
        if (!legal) begin
            dec.reg_write = 1'b0;
            dec.mem_read  = 1'b0;
            dec.mem_write = 1'b0;
            dec.branch    = 1'b0;
            dec.jump      = 1'b0;
        end
        dec.illegal = !legal;
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PW'(1);
            out_d       = dec;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem_q[wr_ptr_q] <= in_instr;
            pc_mem_q[wr_ptr_q]    <= in_pc;
        end
    end

    assign occupancy     = count_q;
    assign out_valid     = out_valid_q;
    assign out_pc        = out_q.pc;
    assign out_rs1       = out_q.rs1;
    assign out_rs2       = out_q.rs2;
    assign out_rd        = out_q.rd;
    assign out_funct3    = out_q.funct3;
    assign out_funct7    = out_q.funct7;
    assign out_branch    = out_q.branch;
    assign out_jump      = out_q.jump;
    assign out_jump_src  = out_q.jump_src;
    assign out_alu_op    = out_q.alu_op;
    assign out_alu_src_a = out_q.alu_src_a;
    assign out_alu_src_b = out_q.alu_src_b;
    assign out_mem_read  = out_q.mem_read;
    assign out_mem_write = out_q.mem_write;
    assign out_mem_mask  = out_q.mem_mask;
    assign out_mem_sext  = out_q.mem_sext;
    assign out_reg_write = out_q.reg_write;
    assign out_wb_src    = out_q.wb_src;
    assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - self-checking bench for decode_stage, one DUT per ENABLE_M setting
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        branch;
        logic        jump;
        logic        jump_src;
        logic [2:0]  alu_op;
        logic        alu_src_a;
        logic [1:0]  alu_src_b;
        logic        mem_read;
        logic        mem_write;
        logic [1:0]  mem_mask;
        logic        mem_sext;
        logic        reg_write;
        logic [1:0]  wb_src;
        logic        illegal;
    } bundle_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } item_t;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, out_ready;
    logic [31:0] in_instr, in_pc;
    logic        in_ready_w  [2];
    logic        out_valid_w [2];
    logic [2:0]  occ_w       [2];
    bundle_t     obs         [2];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic        o_in_ready, o_valid, o_branch, o_jump, o_jump_src, o_src_a;
        logic        o_mem_read, o_mem_write, o_sext, o_reg_write, o_illegal;
        logic [31:0] o_pc;
        logic [4:0]  o_rs1, o_rs2, o_rd;
        logic [2:0]  o_funct3, o_alu_op, o_occ;
        logic [6:0]  o_funct7;
        logic [1:0]  o_src_b, o_mask, o_wb_src;

        decode_stage #(.QUEUE_DEPTH(4), .ENABLE_M(k == 1)) u_dut (
            .clk(clk), .rst_n(rst_n), .flush(flush),
            .in_valid(in_valid), .in_ready(o_in_ready), .in_instr(in_instr), .in_pc(in_pc),
            .out_valid(o_valid), .out_ready(out_ready), .out_pc(o_pc),
            .out_rs1(o_rs1), .out_rs2(o_rs2), .out_rd(o_rd),
            .out_funct3(o_funct3), .out_funct7(o_funct7),
            .out_branch(o_branch), .out_jump(o_jump), .out_jump_src(o_jump_src),
            .out_alu_op(o_alu_op), .out_alu_src_a(o_src_a), .out_alu_src_b(o_src_b),
            .out_mem_read(o_mem_read), .out_mem_write(o_mem_write), .out_mem_mask(o_mask),
            .out_mem_sext(o_sext), .out_reg_write(o_reg_write), .out_wb_src(o_wb_src),
            .out_illegal(o_illegal), .occupancy(o_occ)
        );

        assign obs[k] = {o_pc, o_rs1, o_rs2, o_rd, o_funct3, o_funct7, o_branch, o_jump,
                         o_jump_src, o_alu_op, o_src_a, o_src_b, o_mem_read, o_mem_write,
                         o_mask, o_sext, o_reg_write, o_wb_src, o_illegal};
        assign in_ready_w[k]  = o_in_ready;
        assign out_valid_w[k] = o_valid;
        assign occ_w[k]       = o_occ;
    end

    function automatic logic [1:0] size_mask(input logic [1:0] sz);
        return (sz == 2'd0) ? 2'b01 : (sz == 2'd1) ? 2'b10 : 2'b11;
    endfunction

    // Decoding from the instruction-set rules: decide legality first, then fill the fields
    function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] pc, input bit en_m);
        bundle_t    b;
        logic [6:0] op, f7;
        logic [2:0] f3;
        bit         legal;
        op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
        b = '0;
        b.pc = pc; b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.rd = w[11:7];
        b.funct3 = f3; b.funct7 = f7; b.mem_mask = 2'b11;
        legal = 1'b1;
        case (op)
            7'b0110011: begin
                legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) || (f7 == 7'h01 && en_m);
                b.reg_write = 1'b1;
                b.alu_op = (f7 == 7'h01 && en_m) ? 3'd4 : 3'd2;
            end
            7'b0010011: begin
                legal = !((f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && !(f7 == 7'h00 || f7 == 7'h20)));
                b.alu_op = 3'd3; b.alu_src_b = 2'd1; b.reg_write = 1'b1;
            end
            7'b0000011: begin
                legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
                b.mem_read = 1'b1; b.reg_write = 1'b1; b.wb_src = 2'd1; b.alu_src_b = 2'd1;
                b.mem_mask = size_mask(f3[1:0]);
                b.mem_sext = legal && !f3[2];
            end
            7'b0100011: begin
                legal = (f3 < 3'd3);
                b.mem_write = 1'b1; b.alu_src_b = 2'd1;
                b.mem_mask = legal ? size_mask(f3[1:0]) : 2'b11;
            end
            7'b1100011: begin
                legal = !(f3 == 3'd2 || f3 == 3'd3);
                b.branch = 1'b1; b.alu_op = 3'd1;
            end
            7'b1101111: begin b.jump = 1'b1; b.reg_write = 1'b1; b.wb_src = 2'd2; end
            7'b1100111: begin
                legal = (f3 == 3'd0);
                b.jump = 1'b1; b.jump_src = 1'b1; b.alu_op = 3'd3; b.alu_src_b = 2'd1;
                b.reg_write = 1'b1; b.wb_src = 2'd2;
            end
            7'b0110111: begin b.alu_src_a = 1'b1; b.alu_src_b = 2'd1; b.reg_write = 1'b1; end
            7'b0010111: begin b.alu_src_a = 1'b1; b.alu_src_b = 2'd2; b.reg_write = 1'b1; end
            7'b0001111: ;
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            b.reg_write = 1'b0; b.mem_read = 1'b0; b.mem_write = 1'b0; b.branch = 1'b0; b.jump = 1'b0;
        end
        b.illegal = !legal;
        return b;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 11))
            0: w[6:0] = 7'b0110011;  1: w[6:0] = 7'b0010011;  2: w[6:0] = 7'b0000011;
            3: w[6:0] = 7'b0100011;  4: w[6:0] = 7'b1100011;  5: w[6:0] = 7'b1101111;
            6: w[6:0] = 7'b1100111;  7: w[6:0] = 7'b0110111;  8: w[6:0] = 7'b0010111;
            9: w[6:0] = 7'b0001111; 10: w[6:0] = 7'b1110011;
            default: ;
        endcase
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            2: w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h40; out_ready = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (occ_w[k] !== 3'd0 || out_valid_w[k] !== 1'b0 || in_ready_w[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_ctrl dut%0d occ=%0d valid=%b in_ready=%b want 0/0/0", k, occ_w[k], out_valid_w[k], in_ready_w[k]);
            end
            checks++;
            if (obs[k] !== '0) begin
                errors++;
                $display("FAIL reset_outputs dut%0d got=%h want=0", k, obs[k]);
            end
        end
        rst_n = 1'b1; in_valid = 1'b0;
        cyc();
    endtask

    task automatic test_directed();
        logic [31:0] prog [6] = '{32'h00500093, 32'h00415183, 32'h027302B3,
                                   32'hFFFFFFFF, 32'h00000073, 32'h0000000F};
        logic [31:0] pc;
        for (int i = 0; i < 6; i++) begin
            pc = 32'h1000 + 32'(4 * i);
            in_instr = prog[i]; in_pc = pc; in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready_w[1] !== 1'b1) begin
                errors++;
                $display("FAIL dir_in_ready[%0d] got=%b want=1", i, in_ready_w[1]);
            end
            cyc();
            in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (out_valid_w[1] !== 1'b0) begin
                errors++;
                $display("FAIL dir_early_valid[%0d] got=%b want=0", i, out_valid_w[1]);
            end
            cyc();
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (out_valid_w[k] !== 1'b1 || obs[k] !== ref_decode(prog[i], pc, k == 1)) begin
                    errors++;
                    $display("FAIL dir_bundle[%0d] dut%0d valid=%b got=%h want=%h", i, k, out_valid_w[k], obs[k], ref_decode(prog[i], pc, k == 1));
                end
            end
            checks++;
            case (i)
                0: if ({obs[1].alu_op, obs[1].alu_src_b, obs[1].reg_write, obs[1].rd, obs[1].rs1, obs[1].illegal, obs[1].pc}
                       !== {3'b011, 2'b01, 1'b1, 5'd1, 5'd0, 1'b0, 32'h1000}) begin
                       errors++; $display("FAIL addi_fields got=%h", obs[1]);
                   end
                1: if ({obs[1].mem_read, obs[1].mem_mask, obs[1].mem_sext, obs[1].wb_src, obs[1].reg_write, obs[1].rd, obs[1].rs1}
                       !== {1'b1, 2'b10, 1'b0, 2'b01, 1'b1, 5'd3, 5'd2}) begin
                       errors++; $display("FAIL lhu_fields got=%h", obs[1]);
                   end
                2: if ({obs[1].alu_op, obs[1].illegal, obs[0].illegal, obs[0].reg_write} !== {3'b100, 1'b0, 1'b1, 1'b0}) begin
                       errors++; $display("FAIL mul_fields m=%h nom=%h", obs[1], obs[0]);
                   end
                default: if ({obs[1].illegal, obs[1].reg_write, obs[1].mem_read, obs[1].mem_write, obs[1].branch, obs[1].jump}
                             !== {(i != 5), 5'b00000}) begin
                       errors++; $display("FAIL enables[%0d] got=%h", i, obs[1]);
                   end
            endcase
            cyc();
        end
    endtask

    task automatic test_back_to_back();
        item_t   sent [$];
        bundle_t held;
        int      got;
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_instr = rand_instr(); in_pc = 32'h2000 + 32'(4 * i);
            @(negedge clk);
            if (in_ready_w[1]) sent.push_back('{in_instr, in_pc});
            cyc();
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (sent.size() != 5 || occ_w[1] !== 3'd4 || in_ready_w[1] !== 1'b0 || out_valid_w[1] !== 1'b1) begin
            errors++;
            $display("FAIL full_queue accepted=%0d occ=%0d in_ready=%b valid=%b want 5/4/0/1", sent.size(), occ_w[1], in_ready_w[1], out_valid_w[1]);
        end
        held = obs[1];
        for (int c = 0; c < 3; c++) begin
            cyc();
            @(negedge clk);
            checks++;
            if (obs[1] !== held || out_valid_w[1] !== 1'b1) begin
                errors++;
                $display("FAIL stall_stable got=%h want=%h valid=%b", obs[1], held, out_valid_w[1]);
            end
        end
        cyc();
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            @(negedge clk);
            if (out_valid_w[1]) begin
                for (int k = 0; k < 2; k++) begin
                    checks++;
                    if (obs[k] !== ref_decode(sent[got].instr, sent[got].pc, k == 1)) begin
                        errors++;
                        $display("FAIL drain_order[%0d] dut%0d got=%h want=%h", got, k, obs[k], ref_decode(sent[got].instr, sent[got].pc, k == 1));
                    end
                end
                got++;
            end
            cyc();
        end
        checks++;
        if (got != 5) begin
            errors++;
            $display("FAIL drain_count got=%0d want=5", got);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_instr = 32'h00000013 | (32'(i) << 7); in_pc = 32'h2800 + 32'(4 * i);
            cyc();
        end
        @(negedge clk);
        checks++;
        if (occ_w[1] !== 3'd3 || out_valid_w[1] !== 1'b1) begin
            errors++;
            $display("FAIL flush_setup occ=%0d valid=%b want 3/1", occ_w[1], out_valid_w[1]);
        end
        flush = 1'b1; in_instr = 32'h00500093; in_pc = 32'hDEAD0000;
        @(negedge clk);
        checks++;
        if (in_ready_w[1] !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready got=%b want=0", in_ready_w[1]);
        end
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (out_valid_w[k] !== 1'b0 || occ_w[k] !== 3'd0) begin
                errors++;
                $display("FAIL flush_clear dut%0d valid=%b occ=%0d want 0/0", k, out_valid_w[k], occ_w[k]);
            end
        end
        in_instr = 32'h00415183; in_pc = 32'h3000; in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        @(negedge clk);
        checks++;
        if (out_valid_w[1] !== 1'b1 || obs[1] !== ref_decode(32'h00415183, 32'h3000, 1'b1)) begin
            errors++;
            $display("FAIL post_flush valid=%b got=%h", out_valid_w[1], obs[1]);
        end
        cyc();
        @(negedge clk);
        checks++;
        if (out_valid_w[1] !== 1'b0 || occ_w[1] !== 3'd0) begin
            errors++;
            $display("FAIL post_flush_empty valid=%b occ=%0d want 0/0", out_valid_w[1], occ_w[1]);
        end
    endtask

    task automatic test_random();
        item_t   pend [$];
        bundle_t prev_obs [2];
        bit      prev_stall = 1'b0;
        bundle_t exp_b;
        for (int cyc_n = 0; cyc_n < 900; cyc_n++) begin
            if (cyc_n < 850) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                in_instr  = rand_instr();
                in_pc     = $urandom;
                flush     = ($urandom_range(0, 49) == 0);
                out_ready = flush ? 1'b0 : ($urandom_range(0, 9) < 6);
            end else begin
                in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
            end
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (int'(occ_w[k]) + int'(out_valid_w[k]) != pend.size()) begin
                    errors++;
                    $display("FAIL rnd_count dut%0d occ=%0d valid=%b want_total=%0d", k, occ_w[k], out_valid_w[k], pend.size());
                end
                if (prev_stall) begin
                    checks++;
                    if (obs[k] !== prev_obs[k] || out_valid_w[k] !== 1'b1) begin
                        errors++;
                        $display("FAIL rnd_stall dut%0d got=%h want=%h", k, obs[k], prev_obs[k]);
                    end
                end
            end
            checks++;
            if (in_ready_w[1] !== (!flush && occ_w[1] < 3'd4)) begin
                errors++;
                $display("FAIL rnd_in_ready got=%b occ=%0d flush=%b", in_ready_w[1], occ_w[1], flush);
            end
            if (flush) begin
                pend.delete();
            end else begin
                if (out_valid_w[1] && out_ready) begin
                    checks++;
                    if (pend.size() == 0) begin
                        errors++;
                        $display("FAIL rnd_spurious got=%h want=none", obs[1]);
                    end else begin
                        for (int k = 0; k < 2; k++) begin
                            exp_b = ref_decode(pend[0].instr, pend[0].pc, k == 1);
                            if (k == 1) checks++;
                            if (obs[k] !== exp_b) begin
                                errors++;
                                $display("FAIL rnd_bundle dut%0d got=%h want=%h", k, obs[k], exp_b);
                            end
                        end
                        void'(pend.pop_front());
                    end
                end
                if (in_valid && in_ready_w[1]) pend.push_back('{in_instr, in_pc});
            end
            prev_stall = out_valid_w[1] && !out_ready && !flush;
            prev_obs   = obs;
            cyc();
        end
        checks++;
        if (pend.size() != 0 || out_valid_w[1] !== 1'b0) begin
            errors++;
            $display("FAIL rnd_drain left=%0d valid=%b want 0/0", pend.size(), out_valid_w[1]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Buffered, handshaked RV32I instruction decode stage that sits between fetch and execute. It accepts (instruction, PC) pairs into a QUEUE_DEPTH-entry FIFO and decodes the head entry combinationally. The resulting control bundle is registered into an output stage with valid/ready flow control. Compared with the single-cycle decoder it adds buffering, back-pressure, flush, illegal-instruction detection and an optional M-extension decode mode.

## Interface
- QUEUE_DEPTH, 4, FIFO entries; power of two, ≥2
- ENABLE_M, 0, 1 decodes OP with funct7=0000001 as MUL/DIV; 0 flags it illegal
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  one clock; reset is synchronous and active-low
- flush  in  1  synchronous clear of queue and output stage
- in_valid / in_ready  in/out  1  upstream handshake
- in_instr, in_pc  in  32 each  instruction word and its PC
- out_valid / out_ready  out/in  1  downstream handshake
- out_pc  out  32  PC of decoded instruction
- out_rs1, out_rs2, out_rd  out  5 each  instr[19:15], [24:20], [11:7]
- out_funct3 / out_funct7  out  3 / 7  instr[14:12] / [31:25]
- out_branch, out_jump, out_jump_src  out  1 each  branch; jal/jalr; 0=jal, 1=jalr
- out_alu_op  out  3  000 add (ld/st/lui/auipc), 001 branch, 010 OP, 011 OP-IMM/jalr, 100 MULDIV
- out_alu_src_a  out  1  0 rs1, 1 zero
- out_alu_src_b  out  2  00 rs2, 01 imm, 10 PC+imm
- out_mem_read, out_mem_write  out  1 each
- out_mem_mask  out  2  01 byte, 10 half, 11 word
- out_mem_sext  out  1  load sign-extend
- out_reg_write  out  1
- out_wb_src  out  2  00 ALU, 01 memory, 10 PC+4
- out_illegal  out  1  instruction illegal
- occupancy  out  $clog2(QUEUE_DEPTH)+1  queue entries held

## Operation
- Push: in_valid && in_ready. in_ready = !flush && rst_n && occupancy<QUEUE_DEPTH; it does not depend on out_ready (no comb path).
- Pop: queue non-empty && (!out_valid || out_ready). The head is decoded and loaded into the output stage on the same edge.
- Push and pop may occur in the same cycle; occupancy is then unchanged. Pointers wrap modulo QUEUE_DEPTH.
- Stall: while out_valid && !out_ready, every out_* signal holds stable.
- Decode per opcode:
  - OP 0110011: reg_write, alu_op 010.
  - OP-IMM 0010011: alu_op 011, src_b 01.
  - LOAD 0000011: mem_read, reg_write, wb_src 01, alu_op 000, src_b 01. funct3 0/1/2 give mask 01/10/11 with sext 1; funct3 4/5 give mask 01/10 with sext 0.
  - STORE 0100011: mem_write; funct3 0/1/2 give mask 01/10/11; src_b 01.
  - BRANCH 1100011: branch, alu_op 001.
  - JAL 1101111: jump, reg_write, wb_src 10.
  - JALR 1100111: jump, jump_src 1, alu_op 011, src_b 01, reg_write, wb_src 10.
  - LUI 0110111: alu_op 000, src_a 1, src_b 01, reg_write.
  - AUIPC 0010111: src_a 1, src_b 10, reg_write.
  - FENCE 0001111: legal no-op, all enables 0.
- Defaults for unlisted fields: mask 11, all other fields 0. out_mem_sext is 0 for every non-load.
- out_illegal=1 when any of the following holds:
  - instr[1:0]≠11, or unknown opcode (includes SYSTEM 1110011).
  - LOAD funct3 ∈ {3,6,7}; STORE funct3 >2; BRANCH funct3 ∈ {2,3}; JALR funct3≠0.
  - OP funct7 ∉ {0000000, 0100000, 0000001 if ENABLE_M}; 0100000 is legal only with funct3 0 or 5.
  - OP-IMM funct3 1 with funct7≠0; OP-IMM funct3 5 with funct7 ∉ {0000000, 0100000}.
- Illegal instructions are still passed downstream with out_illegal=1. reg_write, mem_read, mem_write, branch and jump are forced to 0.
- MULDIV (ENABLE_M=1, OP, funct7=0000001): alu_op 100, reg_write 1, src_b 00.

## Timing
- Reset (rst_n=0 at an edge): occupancy 0, out_valid 0, all out_* 0, pointers 0. in_ready stays 0 while rst_n is low.
- Latency: an instruction pushed at edge N into an empty stage with out_ready=1 is popped at edge N+1. out_valid rises in the cycle after edge N+1.
- Throughput: 1 instruction/cycle sustained. Capacity with a stalled consumer is QUEUE_DEPTH+1 (queue plus output stage).
- Full queue: in_ready=0 even when a pop occurs in that cycle.
- flush=1 at an edge: occupancy→0, out_valid→0. No push or pop happens that cycle. Priority is reset > flush > push/pop.
- Reset or flush mid-stall discards all buffered instructions, with no partial output.
- Order is strictly FIFO; no instruction is duplicated or dropped unless flushed.

## Test plan
- addi x1,x0,5 (0x00500093) pushed into an idle stage with out_ready=1 -> out_valid two edges later; alu_op 011, src_b 01, reg_write 1, rd 1, rs1 0, illegal 0, correct out_pc.
- lhu x3,4(x2) (0x00415183) -> mem_read 1, mask 10, sext 0, wb_src 01, reg_write 1, rd 3, rs1 2.
- QUEUE_DEPTH=4, out_ready=0, 6 back-to-back pushes -> 5 accepted, occupancy 4, in_ready 0. Then release out_ready -> 5 outputs in push order with PCs unchanged, out_* stable during the stall.
- mul x5,x6,x7 (0x027302B3): ENABLE_M=1 -> alu_op 100, illegal 0. ENABLE_M=0 -> illegal 1, reg_write 0.
- 0xFFFFFFFF and 0x00000073 -> illegal 1, all enables 0. 0x0000000F -> legal, all enables 0.
- flush asserted with out_valid=1 stalled, occupancy 3 and in_valid=1 in the same cycle -> next cycle out_valid 0, occupancy 0, flush-cycle instruction not accepted. The next push after flush appears normally.
